// File: rtl/alu_sequencer.sv
// Stack-machine ALU sequencer: pops operands, launches the ALU, waits for the result, pushes it.
// One operation in flight; flags underflow, divide-by-zero, ALU timeout and illegal opcodes.
module alu_sequencer #(
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       aluop,
   input  logic [CNT_W-1:0] stack_count,
   input  logic [WIDTH-1:0] stack_top,
   output logic             pop,
   output logic             push,
   output logic [WIDTH-1:0] push_data,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_start,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_result,
   output logic             done,
   output logic [2:0]       err_code,
   input  logic             err_clr
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
   localparam logic [2:0] ERR_DIVZERO   = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT   = 3'd3;
   localparam logic [2:0] ERR_ILLEGAL   = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP_B = 3'd1,
      POP_A = 3'd2,
      EXEC  = 3'd3,
      WAIT  = 3'd4,
      PUSH  = 3'd5,
      ERR   = 3'd6
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      logic ok;
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
         4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b1111: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic op_unary(input logic [3:0] op);
      return (op == 4'b0101);
   endfunction

   function automatic logic op_divides(input logic [3:0] op);
      return (op == 4'b0011) || (op == 4'b0100);
   endfunction

   state_t             state_r;
   logic [TMR_W-1:0]   timer_r;
   logic               divz_r;

   logic               accept_s;
   logic [CNT_W-1:0]   need_s;
   logic               underflow_s;
   logic [TMR_W-1:0]   timer_next_s;

   assign accept_s     = op_valid && op_ready;
   assign need_s       = op_unary(aluop) ? CNT_W'(1) : CNT_W'(2);
   assign underflow_s  = (stack_count < need_s);
   assign timer_next_s = timer_r + TMR_W'(1);

   // Sequencer FSM; every output is registered and set on the edge that enters the state it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         timer_r   <= '0;
         divz_r    <= 1'b0;
         op_ready  <= 1'b1;
         pop       <= 1'b0;
         push      <= 1'b0;
         push_data <= '0;
         alu_op    <= 4'b0000;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_start <= 1'b0;
         done      <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         pop       <= 1'b0;
         push      <= 1'b0;
         alu_start <= 1'b0;
         done      <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  alu_op   <= aluop;
                  op_ready <= 1'b0;
                  if (!op_legal(aluop)) begin
                     err_code <= ERR_ILLEGAL;
                     state_r  <= ERR;
                  end else if (underflow_s) begin
                     err_code <= ERR_UNDERFLOW;
                     state_r  <= ERR;
                  end else begin
                     pop     <= 1'b1;
                     state_r <= POP_B;
                  end
               end else begin
                  op_ready <= 1'b1;
               end
            end
            POP_B: begin
               alu_b <= stack_top;
               if (op_unary(alu_op)) begin
                  // Unary ops see a zero left operand, so neg is computed as 0 - b.
                  alu_a     <= '0;
                  divz_r    <= 1'b0;
                  alu_start <= 1'b1;
                  state_r   <= EXEC;
               end else begin
                  pop     <= 1'b1;
                  state_r <= POP_A;
               end
            end
            POP_A: begin
               alu_a   <= stack_top;
               state_r <= EXEC;
               if (op_divides(alu_op) && (alu_b == '0)) begin
                  divz_r <= 1'b1;
               end else begin
                  divz_r    <= 1'b0;
                  alu_start <= 1'b1;
               end
            end
            EXEC: begin
               timer_r <= '0;
               if (divz_r) begin
                  err_code <= ERR_DIVZERO;
                  state_r  <= ERR;
               end else begin
                  state_r <= WAIT;
               end
            end
            WAIT: begin
               if (alu_done) begin
                  push_data <= alu_result;
                  push      <= 1'b1;
                  done      <= 1'b1;
                  state_r   <= PUSH;
               end else if (timer_next_s == TMR_W'(TIMEOUT - 1)) begin
                  // Fires so that the error becomes visible TIMEOUT cycles after the launch pulse.
                  err_code <= ERR_TIMEOUT;
                  state_r  <= ERR;
               end else begin
                  timer_r <= timer_next_s;
               end
            end
            PUSH: begin
               op_ready <= 1'b1;
               state_r  <= IDLE;
            end
            ERR: begin
               if (err_clr) begin
                  err_code <= ERR_NONE;
                  op_ready <= 1'b1;
                  state_r  <= IDLE;
               end else begin
                  op_ready <= 1'b0;
               end
            end
            default: begin
               err_code <= ERR_NONE;
               op_ready <= 1'b1;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule
